sr_req_sequencer: RTL and testbench

- Front-end stage that drives the S/R inputs of the gate-level SR flip-flop.
- Converts two raw, possibly bouncy level requests (set, clear) into clean, fixed-width S or R pulses.
- Guarantees the downstream flip-flop never sees S=R=1 (its invalid condition).
- Resolves simultaneous requests and serialises back-to-back requests with a guard gap.

---
 rtl/sr_pkg.sv | 27 ++
 rtl/sr_debounce.sv | 62 ++++++
 rtl/sr_req_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_sr_req_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the SR request sequencer:
//   - sr_state_e : sequencer FSM states
//   - PRIO_CLR / PRIO_SET : values for the PRIORITY parameter
//   - cnt_width() : width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GAP     = 2'd3
    } sr_state_e;

    localparam int PRIO_CLR = 0;
    localparam int PRIO_SET = 1;

    // Bits needed to count from 0 up to max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// ---------------------------------------------------------------------------
// sr_debounce
// Cleans one raw asynchronous request level:
//   2-flop synchronizer -> debounce counter -> rising-edge detect.
// The debounced level only changes after DEB_CYCLES consecutive cycles in
// which the synchronized input disagrees with it.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   din   in   raw request level (asynchronous to clk)
//   level out  debounced level (registered)
//   rise  out  one-cycle pulse after the debounced level goes 0->1 (registered)
// ---------------------------------------------------------------------------
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEB_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          rise_r;
    logic [CW-1:0] cnt_r;

    // Synchronizer, debounce counter and rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
                // This is the DEB_CYCLES-th disagreeing cycle: accept the new level.
                level_r <= sync2_r;
                rise_r  <= sync2_r;
                cnt_r   <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/sr_req_sequencer.sv
// ---------------------------------------------------------------------------
// sr_req_sequencer
// Front end for a gate-level SR flip-flop. Debounces raw set/clear request
// levels, turns their rising edges into fixed-width S or R pulses, never
// drives S and R together, resolves simultaneous requests by PRIORITY and
// separates consecutive pulses by a guard gap plus one idle cycle.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   set_req      in   raw set request level (asynchronous)
//   clr_req      in   raw clear request level (asynchronous)
//   S            out  set pulse, registered
//   R            out  reset pulse, registered
//   busy         out  FSM not in IDLE, registered
//   conflict     out  one-cycle pulse when a set/clear tie is resolved
//   conflict_cnt out  [7:0] saturating conflict count
//                     (only when SR_CONFLICT_CNT_EN is defined)
// Build option: define SR_CONFLICT_CNT_EN to add conflict_cnt.
// ---------------------------------------------------------------------------
module sr_req_sequencer
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_W    = 2,
    parameter int GAP_W      = 1,
    parameter int PRIORITY   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       S,
    output logic       R,
    output logic       busy,
`ifdef SR_CONFLICT_CNT_EN
    output logic       conflict,
    output logic [7:0] conflict_cnt
`else
    output logic       conflict
`endif
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW      = cnt_width(CNT_MAX);

    logic          set_level_s;
    logic          clr_level_s;
    logic          set_rise_s;
    logic          clr_rise_s;
    logic          levels_unused_s;

    sr_state_e     state_r;
    sr_state_e     state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          set_pend_r;
    logic          clr_pend_r;
    logic          take_set_s;
    logic          take_clr_s;
    logic          conflict_s;
    logic          s_r;
    logic          r_r;
    logic          busy_r;
    logic          conflict_r;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
        .clk   (clk),
        .rst   (rst),
        .din   (set_req),
        .level (set_level_s),
        .rise  (set_rise_s)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst   (rst),
        .din   (clr_req),
        .level (clr_level_s),
        .rise  (clr_rise_s)
    );

    // Only the edges matter here; the levels are kept for observability.
    assign levels_unused_s = set_level_s ^ clr_level_s;

    // Single-depth pending flags; a fresh edge wins over a same-cycle take.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_pend_r <= 1'b0;
            clr_pend_r <= 1'b0;
        end else begin
            set_pend_r <= (set_pend_r & ~take_set_s) | set_rise_s;
            clr_pend_r <= (clr_pend_r & ~take_clr_s) | clr_rise_s;
        end
    end

    // FSM state, phase counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            s_r        <= (state_s == DRIVE_S);
            r_r        <= (state_s == DRIVE_R);
            busy_r     <= (state_s != IDLE);
            conflict_r <= conflict_s;
        end
    end

    // Next-state logic: arbitration in IDLE, pulse and gap timing elsewhere.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        take_set_s = 1'b0;
        take_clr_s = 1'b0;
        conflict_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CW{1'b0}};
                if (set_pend_r && clr_pend_r) begin
                    // Tie: the loser is dropped, not deferred.
                    take_set_s = 1'b1;
                    take_clr_s = 1'b1;
                    conflict_s = 1'b1;
                    state_s    = (PRIORITY == PRIO_SET) ? DRIVE_S : DRIVE_R;
                end else if (set_pend_r) begin
                    take_set_s = 1'b1;
                    state_s    = DRIVE_S;
                end else if (clr_pend_r) begin
                    take_clr_s = 1'b1;
                    state_s    = DRIVE_R;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (cnt_r == CW'(PULSE_W - 1)) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = (GAP_W == 0) ? IDLE : GAP;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            GAP: begin
                if (cnt_r == CW'(GAP_W - 1)) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                cnt_s   = {CW{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

`ifdef SR_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt_r;

    // Saturating count of resolved set/clear ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_r <= 8'd0;
        end else if (conflict_s && (conflict_cnt_r != 8'd255)) begin
            conflict_cnt_r <= conflict_cnt_r + 8'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

    assign S        = s_r;
    assign R        = r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;

endmodule

// File: tb/tb_sr_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_req_sequencer
// Directed bench for sr_req_sequencer with DEB_CYCLES=4, PULSE_W=2, GAP_W=1.
// Two instances share the stimulus: dut0 with PRIORITY=0 (clear wins) and
// dut1 with PRIORITY=1 (set wins). Cycle index i counts the clk edges since
// a stimulus window opened; an input changed for index i is first sampled
// at edge i, and outputs are read 1 time unit after that edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sr_req_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_req;
    logic       clr_req;
    logic [1:0] s_v;
    logic [1:0] r_v;
    logic [1:0] busy_v;
    logic [1:0] conf_v;
`ifdef SR_CONFLICT_CNT_EN
    logic [7:0] cc0;
    logic [7:0] cc1;
`endif

    int errors = 0;
    int checks = 0;

    int s_cnt[2], r_cnt[2], b_cnt[2], c_cnt[2];
    int s_first[2], r_first[2], b_first[2], c_first[2];

    always #5 clk = ~clk;

    sr_req_sequencer #(.DEB_CYCLES(4), .PULSE_W(2), .GAP_W(1), .PRIORITY(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .S        (s_v[0]),
        .R        (r_v[0]),
        .busy     (busy_v[0]),
`ifdef SR_CONFLICT_CNT_EN
        .conflict (conf_v[0]),
        .conflict_cnt (cc0)
`else
        .conflict (conf_v[0])
`endif
    );

    sr_req_sequencer #(.DEB_CYCLES(4), .PULSE_W(2), .GAP_W(1), .PRIORITY(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .S        (s_v[1]),
        .R        (r_v[1]),
        .busy     (busy_v[1]),
`ifdef SR_CONFLICT_CNT_EN
        .conflict (conf_v[1]),
        .conflict_cnt (cc1)
`else
        .conflict (conf_v[1])
`endif
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive set_req high for indices [s_on, s_off) and clr_req for [c_on, c_off),
    // run n edges and collect per-instance counts and first-high indices.
    task automatic run(input int n, input int s_on, input int s_off,
                       input int c_on, input int c_off);
        for (int d = 0; d < 2; d++) begin
            s_cnt[d] = 0; r_cnt[d] = 0; b_cnt[d] = 0; c_cnt[d] = 0;
            s_first[d] = -1; r_first[d] = -1; b_first[d] = -1; c_first[d] = -1;
        end
        for (int i = 1; i <= n; i++) begin
            set_req = (i >= s_on && i < s_off) ? 1'b1 : 1'b0;
            clr_req = (i >= c_on && i < c_off) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("s_and_r_excl", {31'd0, s_v[d] & r_v[d]}, 32'd0);
                if (s_v[d] === 1'b1) begin
                    s_cnt[d]++;
                    if (s_first[d] < 0) s_first[d] = i;
                end
                if (r_v[d] === 1'b1) begin
                    r_cnt[d]++;
                    if (r_first[d] < 0) r_first[d] = i;
                end
                if (busy_v[d] === 1'b1) begin
                    b_cnt[d]++;
                    if (b_first[d] < 0) b_first[d] = i;
                end
                if (conf_v[d] === 1'b1) begin
                    c_cnt[d]++;
                    if (c_first[d] < 0) c_first[d] = i;
                end
            end
        end
        set_req = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        int len[2];
        int last_start[2];
        int prev[2];
        int p;

        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_S", {30'd0, s_v}, 32'd0);
        chk("rst_R", {30'd0, r_v}, 32'd0);
        chk("rst_busy", {30'd0, busy_v}, 32'd0);
        chk("rst_conflict", {30'd0, conf_v}, 32'd0);
        rst = 1'b0;
        run(4, 0, 0, 0, 0);

        // Clean set request held 12 cycles: S at indices 8,9; busy 8..10.
        run(24, 1, 13, 0, 0);
        chk("set_s_first", s_first[0], 32'd8);
        chk("set_s_count", s_cnt[0], 32'd2);
        chk("set_r_count", r_cnt[0], 32'd0);
        chk("set_busy_first", b_first[0], 32'd8);
        chk("set_busy_count", b_cnt[0], 32'd3);
        chk("set_conflict", c_cnt[0], 32'd0);
        chk("set_s_count_p1", s_cnt[1], 32'd2);

        // Three-cycle clear glitch never survives the debouncer.
        run(20, 0, 0, 1, 4);
        chk("glitch_r_count", r_cnt[0], 32'd0);
        chk("glitch_busy", b_cnt[0], 32'd0);
        chk("glitch_r_count_p1", r_cnt[1], 32'd0);

        // Simultaneous requests: clear wins on dut0, set wins on dut1.
        run(24, 1, 11, 1, 11);
        chk("tie_p0_r_first", r_first[0], 32'd8);
        chk("tie_p0_r_count", r_cnt[0], 32'd2);
        chk("tie_p0_s_count", s_cnt[0], 32'd0);
        chk("tie_p0_conf_count", c_cnt[0], 32'd1);
        chk("tie_p0_conf_first", c_first[0], 32'd8);
        chk("tie_p1_s_first", s_first[1], 32'd8);
        chk("tie_p1_s_count", s_cnt[1], 32'd2);
        chk("tie_p1_r_count", r_cnt[1], 32'd0);
        chk("tie_p1_conf_count", c_cnt[1], 32'd1);
`ifdef SR_CONFLICT_CNT_EN
        chk("tie_p0_conf_cnt", {24'd0, cc0}, 32'd1);
        chk("tie_p1_conf_cnt", {24'd0, cc1}, 32'd1);
`endif

        // Set then clear one cycle later: S 8-9, gap 10, idle 11, R 12-13.
        run(28, 1, 13, 2, 14);
        chk("seq_s_first", s_first[0], 32'd8);
        chk("seq_s_count", s_cnt[0], 32'd2);
        chk("seq_r_first", r_first[0], 32'd12);
        chk("seq_r_count", r_cnt[0], 32'd2);
        chk("seq_conflict", c_cnt[0], 32'd0);
        chk("seq_busy_count", b_cnt[0], 32'd6);
        chk("seq_r_first_p1", r_first[1], 32'd12);

        // Reset during the second cycle of an S pulse.
        run(8, 1, 99, 0, 0);
        chk("mid_s_started", s_first[0], 32'd8);
        rst     = 1'b1;
        set_req = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_S", {30'd0, s_v}, 32'd0);
        chk("mid_rst_R", {30'd0, r_v}, 32'd0);
        chk("mid_rst_busy", {30'd0, busy_v}, 32'd0);
        chk("mid_rst_conflict", {30'd0, conf_v}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(20, 0, 0, 0, 0);
        chk("post_rst_s_count", s_cnt[0], 32'd0);
        chk("post_rst_busy", b_cnt[0], 32'd0);

        // Bouncy random stimulus: exclusivity, pulse width and spacing.
        for (int d = 0; d < 2; d++) begin
            len[d] = 0;
            last_start[d] = -1;
            prev[d] = 0;
        end
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if ($urandom_range(0, 5) == 0) set_req = ~set_req;
            if ($urandom_range(0, 5) == 0) clr_req = ~clr_req;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("rnd_s_and_r", {31'd0, s_v[d] & r_v[d]}, 32'd0);
                p = (s_v[d] === 1'b1 || r_v[d] === 1'b1) ? 1 : 0;
                if (p == 1 && prev[d] == 0) begin
                    if (last_start[d] >= 0) begin
                        chk("rnd_spacing", (cyc - last_start[d] >= 4) ? 32'd1 : 32'd0, 32'd1);
                    end
                    last_start[d] = cyc;
                    len[d] = 1;
                end else if (p == 1) begin
                    len[d]++;
                end else if (prev[d] == 1) begin
                    chk("rnd_pulse_w", len[d], 32'd2);
                end
                prev[d] = p;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
